// File: rtl/window_filter_3x3.sv
// 3x3 window assembler and kernel filter fed by the 3-row line buffer; one output per beat, 2-cycle latency.
// Optional Sobel kernel (mode 3) is built only when WINDOW_FILTER_SOBEL_EN is defined; otherwise mode 3 is a pass-through.
module window_filter_3x3 #(
  parameter int WIDTH      = 320,
  parameter int HEIGHT     = 240,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] tap_top,
  input  logic [DATA_WIDTH-1:0] tap_mid,
  input  logic [DATA_WIDTH-1:0] tap_bot,
  input  logic [1:0]            mode,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] pixel_out,
  output logic                  frame_done
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 2;
  localparam int RW = (HEIGHT > 2) ? $clog2(HEIGHT) : 2;
  localparam int AW = DATA_WIDTH + 4;
  localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);
  localparam logic [DATA_WIDTH-1:0] PMAX = '1;

  logic [CW-1:0]         col;
  logic [RW-1:0]         row;
  logic [DATA_WIDTH-1:0] w [3][3];  // [row: 0=top][col: 0=oldest/west]
  logic                  v1, interior1, last1;
  logic [1:0]            mode_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      col       <= '0;
      row       <= '0;
      mode_q    <= '0;
      v1        <= 1'b0;
      interior1 <= 1'b0;
      last1     <= 1'b0;
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          w[i][j] <= '0;
    end else begin
      v1 <= in_valid;
      if (in_valid) begin
        for (int i = 0; i < 3; i++) begin
          w[i][0] <= w[i][1];
          w[i][1] <= w[i][2];
        end
        w[0][2]   <= tap_top;
        w[1][2]   <= tap_mid;
        w[2][2]   <= tap_bot;
        interior1 <= (col >= CW'(2)) && (row >= RW'(2));
        last1     <= (col == COL_LAST) && (row == ROW_LAST);
        if (col == COL_LAST) begin
          col <= '0;
          row <= (row == ROW_LAST) ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
        // Kernel is chosen once per frame, on its first beat
        if (col == '0 && row == '0)
          mode_q <= mode;
      end
    end
  end

  logic signed [AW-1:0] nw, n, ne, wv, cv, ev, sw, s, se;
  logic signed [AW-1:0] gauss, sharp;
  logic [DATA_WIDTH-1:0] kern;

  assign nw = AW'(w[0][0]);
  assign n  = AW'(w[0][1]);
  assign ne = AW'(w[0][2]);
  assign wv = AW'(w[1][0]);
  assign cv = AW'(w[1][1]);
  assign ev = AW'(w[1][2]);
  assign sw = AW'(w[2][0]);
  assign s  = AW'(w[2][1]);
  assign se = AW'(w[2][2]);

  function automatic logic [DATA_WIDTH-1:0] clamp(input logic signed [AW-1:0] x);
    if (x[AW-1])
      return '0;
    else if (|x[AW-2:DATA_WIDTH])
      return PMAX;
    else
      return x[DATA_WIDTH-1:0];
  endfunction

  assign gauss = (cv <<< 2) + ((n + s + ev + wv) <<< 1) + nw + ne + sw + se;
  assign sharp = (cv <<< 2) + cv - n - s - ev - wv;

`ifdef WINDOW_FILTER_SOBEL_EN
  logic signed [AW-1:0] gx, gy, ax, ay;
  assign gx = (ne + (ev <<< 1) + se) - (nw + (wv <<< 1) + sw);
  assign gy = (sw + (s <<< 1) + se) - (nw + (n <<< 1) + ne);
  assign ax = gx[AW-1] ? -gx : gx;
  assign ay = gy[AW-1] ? -gy : gy;
`endif

  always_comb begin
    kern = w[1][1];
    case (mode_q)
      2'd1: kern = DATA_WIDTH'(gauss >>> 4);
      2'd2: kern = clamp(sharp);
`ifdef WINDOW_FILTER_SOBEL_EN
      2'd3: kern = clamp(ax + ay);
`endif
      default: kern = w[1][1];
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid  <= 1'b0;
      pixel_out  <= '0;
      frame_done <= 1'b0;
    end else begin
      out_valid  <= v1;
      frame_done <= v1 && last1;
      pixel_out  <= (v1 && interior1) ? kern : '0;
    end
  end
endmodule

// File: doc/window_filter_3x3.md
Name: window_filter_3x3

Overview:
- Consumer side of the 3-row line buffer.
- Accepts one vertical column of three pixel taps per beat and assembles a 3x3 window in column shift registers.
- Applies a selectable 3x3 kernel and emits one filtered pixel per accepted beat, with fixed latency.
- Sits between the line buffer and the output frame writer in the grayscale image-filter path.

Parameters:
- WIDTH, 320: pixels per line; col counter wraps at WIDTH-1.
- HEIGHT, 240: lines per frame; row counter wraps at HEIGHT-1.
- DATA_WIDTH, 8: bits per pixel; results clamp to 2^DATA_WIDTH-1.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  taps valid this cycle; same strobe as the line buffer enable.
- tap_top  in  DATA_WIDTH  pixel from row r-2 (oldest).
- tap_mid  in  DATA_WIDTH  pixel from row r-1.
- tap_bot  in  DATA_WIDTH  pixel from row r (live input).
- mode  in  2  kernel select: 0 pass, 1 gaussian, 2 sharpen, 3 sobel.
- out_valid  out  1  pixel_out valid.
- pixel_out  out  DATA_WIDTH  filtered pixel.
- frame_done  out  1  one-cycle pulse coincident with the last output of a frame.

Behaviour:
- Reset: col, row, window registers, mode_q and the pipeline are all cleared. out_valid=0, pixel_out=0, frame_done=0 from the cycle after reset is sampled.
- Reset mid-frame abandons the frame with no frame_done. The upstream line buffer is reset in the same cycle.
- Beat at (col,row) with in_valid=1, stage 1 (window):
  - Window columns shift: w[*][0] <= w[*][1], w[*][1] <= w[*][2], w[*][2] <= {tap_top, tap_mid, tap_bot}.
  - col/row advance: col wraps WIDTH-1 -> 0 and increments row; row wraps HEIGHT-1 -> 0.
  - Flags pipelined alongside the window:
    - interior = (col>=2 && row>=2).
    - last = (col==WIDTH-1 && row==HEIGHT-1).
  - mode_q <= mode only on the beat at (0,0). Mode changes mid-frame are ignored until the next frame.
- Cycles with in_valid=0: window, counters and mode_q hold. The pipeline still advances, so a bubble produces out_valid=0.
- Stage 2 (arithmetic): the kernel is computed combinationally from the window and registered.
  - out_valid is high exactly 2 cycles after each in_valid beat.
  - No backpressure.
- Output for the beat at (c,r) is the window centred at (c-1,r-1). If interior=0, pixel_out=0 (border and priming rows/columns), including windows that straddle the row wrap.
- Kernels (C = centre; N,S,E,W = edge neighbours; K = corner neighbours):
  - mode 0: pixel_out = C.
  - mode 1: (4C + 2(N+S+E+W) + sum of K) >> 4. Accumulator is DATA_WIDTH+4 bits, no rounding.
  - mode 2: 5C - N - S - E - W. Signed DATA_WIDTH+4 bits, clamped to [0, 2^DATA_WIDTH-1].
  - mode 3: see Optional Feature.
- frame_done = out_valid of the beat flagged last. Counters are back at (0,0) after that beat.

Optional Feature:
- Macro: WINDOW_FILTER_SOBEL_EN.
- Defined: mode 3 computes |Gx|+|Gy|, saturated to 2^DATA_WIDTH-1.
  - Gx = (NE + 2E + SE) - (NW + 2W + SW).
  - Gy = (SW + 2S + SE) - (NW + 2N + NE).
  - Signed intermediates DATA_WIDTH+4 bits.
- Not defined: no Sobel logic is synthesized; mode 3 behaves exactly as mode 0.

Test Plan:
- WIDTH=8, HEIGHT=6, constant 100, mode 1, continuous in_valid -> 48 outputs, each 2 cycles after its beat. Outputs are 0 for row<2 or col<2 and 100 elsewhere; frame_done on the 48th.
- mode 2, black field with 200 at (4,3) -> beat (5,4) outputs 255 (1000 clamped). Beats (4,4), (6,4), (5,3), (5,5) output 0 (negative clamped); all others 0.
- mode 0, ramp pixel = 10*row + col -> beat (c,r) with c>=2, r>=2 outputs 10*(r-1) + (c-1).
- Constant 100, mode 1, random in_valid gaps (~30% idle) -> output values identical to the gap-free run. out_valid count equals the beat count; no output appears during idle cycles.
- mode changed 1 -> 2 at beat 20 of a frame -> the rest of that frame still uses mode 1; the next frame uses mode 2.
- Reset asserted at beat 20 -> out_valid=0 and pixel_out=0 the next cycle, no frame_done. The next frame outputs match a clean run.
- Optional feature, with WINDOW_FILTER_SOBEL_EN defined, mode 3, columns 0-3 = 0 and columns 4-7 = 200:
  - Beats with c-1 in {3,4} (interior) output 255; all other beats output 0.
  - With the macro undefined, the same stimulus matches mode 0.
